// File: rtl/axis_fifo.sv
// AXI-Stream first-word-fall-through FIFO, count-based full/empty.
// Optional tlast sideband: define AXIS_FIFO_TLAST_EN.
module axis_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
`ifdef AXIS_FIFO_TLAST_EN
  input  logic                     s_axis_tlast,
  output logic                     m_axis_tlast,
`endif
  output logic [DATA_WIDTH-1:0]    m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_nx;
  logic                  valid_q;
  logic                  full;
  logic                  push;
  logic                  pop;

  assign full          = (count == CW'(DEPTH));
  assign s_axis_tready = !full && !rst_i;
  assign push          = s_axis_tvalid && s_axis_tready;
  assign pop           = valid_q && m_axis_tready;
  assign count_o       = count;
  assign m_axis_tvalid = valid_q;

  always_comb begin
    count_nx = count;
    unique case (1'b1)
      (push && !pop): count_nx = count + CW'(1);
      (pop && !push): count_nx = count - CW'(1);
      default:        count_nx = count;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count   <= count_nx;
      valid_q <= (count_nx != '0);
    end
  end

  // Storage is not reset; the valid mask keeps stale words off the output.
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= s_axis_tdata;
  end

  assign m_axis_tdata = valid_q ? mem[rptr] : '0;

`ifdef AXIS_FIFO_TLAST_EN
  logic last_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (push) last_mem[wptr] <= s_axis_tlast;
  end

  assign m_axis_tlast = valid_q ? last_mem[rptr] : 1'b0;
`endif

endmodule

// File: tb/tb_axis_fifo.sv
// Scoreboard bench for axis_fifo: queue reference model, negedge monitor.
// Covers directed corner cases plus a randomized streaming phase.
module tb_axis_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic          m_tlast;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic [4:0]    count_o;

  int nvec = 0;
  int nerr = 0;

  logic [DW:0] q[$];
  bit          rdy;

  always #5 clk_i = ~clk_i;

  axis_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
`ifdef AXIS_FIFO_TLAST_EN
    .s_axis_tlast  (s_tlast),
    .m_axis_tlast  (m_tlast),
`endif
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .count_o       (count_o)
  );

`ifndef AXIS_FIFO_TLAST_EN
  assign m_tlast = 1'b0;
`endif

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endfunction

  // Monitor + reference model: state seen here is the result of the last edge;
  // the transfers decided here take effect on the next edge.
  always @(negedge clk_i) begin
    rdy = q.size() < DEPTH;
    if (rst_i) begin
      q.delete();
      chk("rst_count", 32'(count_o), 0);
      chk("rst_tvalid", 32'(m_tvalid), 0);
      chk("rst_s_tready", 32'(s_tready), 0);
      chk("rst_tdata", 32'(m_tdata), 0);
    end else begin
      chk("count", 32'(count_o), 32'(q.size()));
      chk("tvalid", 32'(m_tvalid), 32'(q.size() != 0));
      chk("s_tready", 32'(s_tready), 32'(rdy));
      if (q.size() != 0) begin
        chk("tdata", 32'(m_tdata), 32'(q[0][DW-1:0]));
`ifdef AXIS_FIFO_TLAST_EN
        chk("tlast", 32'(m_tlast), 32'(q[0][DW]));
`endif
        if (m_tready) void'(q.pop_front());
      end
      if (s_tvalid && rdy) q.push_back({s_tlast, s_tdata});
    end
  end

  task automatic drive(input logic v, input logic [DW-1:0] d,
                       input logic r, input logic l);
    @(posedge clk_i);
    #1;
    s_tvalid = v;
    s_tdata  = d;
    m_tready = r;
    s_tlast  = l;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 4; i++) drive(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    rst_i    = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // single word, held under backpressure
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // fill to full, offer a rejected word, then pop while full
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
    drive(1'b1, 8'h10, 1'b0, 1'b0);
    drive(1'b1, 8'h10, 1'b0, 1'b0);
    drive(1'b1, 8'h10, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drain();

    // steady streaming at fill level 4 across two pointer wraps
    for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) drive(1'b1, 8'(8'h44 + i), 1'b1, 1'b0);
    drain();

    // async reset with 7 words held
    for (int i = 0; i < 7; i++) drive(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h77 + i), 1'b1, 1'b0);
    @(posedge clk_i);
    #3 rst_i = 1'b1;
    #1;
    chk("async_count", 32'(count_o), 0);
    chk("async_tvalid", 32'(m_tvalid), 0);
    s_tvalid = 1'b0;
    repeat (2) @(posedge clk_i);
    #2 rst_i = 1'b0;
    drive(1'b1, 8'h3C, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);

`ifdef AXIS_FIFO_TLAST_EN
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    drive(1'b1, 8'h22, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drain();
`endif

    // randomized traffic with varying bias
    for (int i = 0; i < 1500; i++) begin
      int bv, br;
      bv = (i / 300) % 2 == 0 ? 3 : 1;
      br = (i / 300) % 2 == 0 ? 1 : 3;
      drive($urandom_range(0, 3) < bv, 8'($urandom), $urandom_range(0, 3) < br,
            1'($urandom));
    end
    drain();

    @(negedge clk_i);
    @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/axis_fifo.md
AXIS_FIFO -- requirements
Module: axis_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the tdata width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, giving the storage entries; power of two, >=2.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port s_axis_tdata  input  DATA_WIDTH  upstream data.
REQ-006 SHALL have port s_axis_tvalid  input  1  upstream valid.
REQ-007 SHALL have port s_axis_tready  output  1  FIFO can accept.
REQ-008 SHALL have port m_axis_tdata  output  DATA_WIDTH  downstream data.
REQ-009 SHALL have port m_axis_tvalid  output  1  downstream valid.
REQ-010 SHALL have port m_axis_tready  input  1  downstream ready.
REQ-011 SHALL have port count_o  output  $clog2(DEPTH)+1  words held, including any word presented on m_axis.

Function
REQ-012 SHALL accept a word on every clk_i edge with s_axis_tvalid && s_axis_tready (push), and release one on every edge with m_axis_tvalid && m_axis_tready (pop).
REQ-013 SHALL drive s_axis_tready = (count_o < DEPTH) && !rst_i; no write-through when full, even with a simultaneous pop.
REQ-014 SHALL be first-word-fall-through: a word pushed into an empty FIFO appears on m_axis with m_axis_tvalid high exactly 1 cycle after the push edge; no same-cycle combinational bypass.
REQ-015 SHALL deliver words in push order, none lost or duplicated.
REQ-016 SHALL hold m_axis_tdata and m_axis_tvalid stable while m_axis_tvalid && !m_axis_tready.
REQ-017 SHALL assert m_axis_tvalid iff count_o > 0, registered.
REQ-018 SHALL update count_o as: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop; never exceeds DEPTH, never underflows.
REQ-019 SHALL keep streaming at 1 word/cycle with both tvalid and tready held high, at any fill level 1..DEPTH-1.
REQ-020 SHALL use read/write pointers of $clog2(DEPTH) bits wrapping modulo DEPTH; full/empty derived from count, not pointer equality alone.
REQ-021 SHALL accept and ignore input data when s_axis_tvalid is low; s_axis_tready is independent of s_axis_tvalid.

Reset
REQ-022 SHALL, while rst_i is high, force count_o=0, m_axis_tvalid=0, s_axis_tready=0, pointers=0, m_axis_tdata=0.
REQ-023 SHALL discard all stored words on reset asserted mid-transfer; storage array contents need not be cleared.
REQ-024 SHALL drive s_axis_tready=1 in the first cycle after rst_i deasserts.

Configuration
REQ-025 SHALL, when macro AXIS_FIFO_TLAST_EN is defined, add ports s_axis_tlast (input, 1) and m_axis_tlast (output, 1), store tlast alongside each word, and present it with that word under REQ-014..REQ-016; reset value of m_axis_tlast is 0.
REQ-026 SHALL, without AXIS_FIFO_TLAST_EN, have no tlast ports or storage, all other behaviour identical.

Verification
REQ-027 SHALL cover: reset, push 0xA5 with m_axis_tready=0 -> m_axis_tvalid=1, tdata=0xA5 one cycle later; count_o=1; tdata held for 5 cycles until tready.
REQ-028 SHALL cover: DEPTH=16, push 0x00..0x0F with no pops -> s_axis_tready=0 after 16th push, count_o=16; 17th word 0x10 offered is not taken; drain yields 0x00..0x0F in order.
REQ-029 SHALL cover: full FIFO, tvalid and tready both high one cycle -> one pop only, count_o=15, s_axis_tready=1 next cycle.
REQ-030 SHALL cover: count_o=4, continuous push/pop for 40 cycles (pointer wrap twice) -> count_o stays 4, output sequence matches input sequence with 4-word lag.
REQ-031 SHALL cover: rst_i asserted asynchronously mid-stream with count_o=7 -> count_o=0, m_axis_tvalid=0 without a clock edge; after release first push 0x3C is first word out.
REQ-032 SHALL cover, with AXIS_FIFO_TLAST_EN: push 0x11(last=0), 0x22(last=1) -> m_axis_tlast=0 with 0x11, 1 with 0x22.
